// File: rtl/request_unit.sv
// request_unit: memory request sequencer for the single-cycle datapath.
//
// It sits directly after the instruction decoder. It holds each data request
// stable until dhit arrives, stalls the PC while a memory access is in
// flight, and latches halt until the next reset.
//
// Optional feature: define REQUEST_UNIT_PERF_EN to add the saturating
// performance counters instr_count and stall_count. In the default build
// those ports and their logic are absent.
//
// Ports:
//   CLK          system clock, rising edge
//   nRST         asynchronous active-low reset
//   ihit         instruction fetch complete this cycle
//   dhit         data access complete this cycle
//   dRENi        decoder: load
//   dWENi        decoder: store
//   halt         decoder: HALT
//   imemREN      instruction read request (combinational)
//   dmemREN      data read request (registered)
//   dmemWEN      data write request (registered)
//   pcEN         advance PC / commit this cycle (combinational)
//   halted       sticky halt flag (registered)
//   instr_count  retired instructions (REQUEST_UNIT_PERF_EN only)
//   stall_count  stall cycles, HALT excluded (REQUEST_UNIT_PERF_EN only)
//
// state | meaning
// FETCH | instruction port owned; commit immediately on ihit if no access
// MEM   | registered data request outstanding until dhit
// HALT  | sticky stop; only nRST leaves
module request_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dRENi,
  input  logic             dWENi,
  input  logic             halt,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pcEN,
  output logic             halted
`ifdef REQUEST_UNIT_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MEM   = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state, state_n;
  logic   dmem_ren_n, dmem_wen_n, halted_n;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= FETCH;
      dmemREN <= 1'b0;
      dmemWEN <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_n;
      dmemREN <= dmem_ren_n;
      dmemWEN <= dmem_wen_n;
      halted  <= halted_n;
    end
  end

  always_comb begin
    state_n    = state;
    dmem_ren_n = dmemREN;
    dmem_wen_n = dmemWEN;
    halted_n   = halted;
    imemREN    = 1'b0;
    pcEN       = 1'b0;
    case (state)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (halt) begin
            // halt wins over any load/store strobe decoded alongside it
            state_n  = HALT;
            halted_n = 1'b1;
          end else if (dWENi) begin
            // an illegal load+store decode resolves to a store
            state_n    = MEM;
            dmem_wen_n = 1'b1;
            dmem_ren_n = 1'b0;
          end else if (dRENi) begin
            state_n    = MEM;
            dmem_ren_n = 1'b1;
          end else begin
            pcEN = 1'b1;
          end
        end
      end
      MEM: begin
        // The decoder strobes may already reflect the next instruction, so
        // only the registered request is used here.
        if (dhit) begin
          pcEN       = 1'b1;
          dmem_ren_n = 1'b0;
          dmem_wen_n = 1'b0;
          state_n    = FETCH;
        end
      end
      HALT: begin
        dmem_ren_n = 1'b0;
        dmem_wen_n = 1'b0;
        halted_n   = 1'b1;
      end
      default: begin
        state_n    = FETCH;
        dmem_ren_n = 1'b0;
        dmem_wen_n = 1'b0;
      end
    endcase
  end

`ifdef REQUEST_UNIT_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_count <= '0;
      stall_count <= '0;
    end else if (state != HALT) begin
      if (pcEN) begin
        if (instr_count != CNT_MAX) instr_count <= instr_count + 1'b1;
      end else begin
        if (stall_count != CNT_MAX) stall_count <= stall_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit. A behavioural model tracks the
// outstanding data request and the halt flag, and it derives the expected
// outputs from the sequencing rules. The counter checks are compiled only
// when REQUEST_UNIT_PERF_EN is defined.
module tb_request_unit;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic CLK = 1'b0;
  logic nRST, ihit, dhit, dRENi, dWENi, halt;
  logic imemREN, dmemREN, dmemWEN, pcEN, halted;
`ifdef REQUEST_UNIT_PERF_EN
  logic [CW-1:0] instr_count, stall_count;
`endif

  request_unit #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dRENi(dRENi),
    .dWENi(dWENi), .halt(halt), .imemREN(imemREN), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .pcEN(pcEN), .halted(halted)
`ifdef REQUEST_UNIT_PERF_EN
    , .instr_count(instr_count), .stall_count(stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  // model: pending request kind (0 none, 1 read, 2 write), halt flag, counts
  int m_pend = 0;
  bit m_halt = 0;
  int m_ic = 0;
  int m_sc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_halt = 0; m_ic = 0; m_sc = 0;
  endtask

  task automatic chk_counters();
`ifdef REQUEST_UNIT_PERF_EN
    chk("instr_count", 32'(instr_count), 32'(m_ic));
    chk("stall_count", 32'(stall_count), 32'(m_sc));
`endif
  endtask

  // One clock cycle: drive inputs after the falling edge, check the outputs,
  // then advance the model across the rising edge.
  task automatic cycle(input logic i, input logic d, input logic r, input logic w, input logic h);
    logic e_pc;
    @(negedge CLK);
    ihit = i; dhit = d; dRENi = r; dWENi = w; halt = h;
    #1;
    if (m_halt) e_pc = 1'b0;
    else if (m_pend == 0) e_pc = i && !h && !r && !w;
    else e_pc = d;
    chk("imemREN", 32'(imemREN), 32'(!m_halt && m_pend == 0));
    chk("dmemREN", 32'(dmemREN), 32'(m_pend == 1));
    chk("dmemWEN", 32'(dmemWEN), 32'(m_pend == 2));
    chk("pcEN", 32'(pcEN), 32'(e_pc));
    chk("halted", 32'(halted), 32'(m_halt));
    chk_counters();
    @(posedge CLK);
    if (!m_halt) begin
      if (e_pc) m_ic = (m_ic < CMAX) ? m_ic + 1 : CMAX;
      else m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      if (m_pend == 0 && i) begin
        if (h) m_halt = 1;
        else if (w) m_pend = 2;
        else if (r) m_pend = 1;
      end else if (m_pend != 0 && d) begin
        m_pend = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    ihit = 0; dhit = 0; dRENi = 0; dWENi = 0; halt = 0;
    #1;
    model_reset();
    chk("rst_imemREN", 32'(imemREN), 32'd1);
    chk("rst_dmemREN", 32'(dmemREN), 32'd0);
    chk("rst_dmemWEN", 32'(dmemWEN), 32'd0);
    chk("rst_pcEN", 32'(pcEN), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk_counters();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 0; dhit = 0; dRENi = 0; dWENi = 0; halt = 0;
    do_reset();

    // three zero-latency commits
    repeat (3) cycle(1, 0, 0, 0, 0);
`ifdef REQUEST_UNIT_PERF_EN
    #1 chk("ic_after_3", 32'(instr_count), 32'd3);
`endif

    // load with two stall cycles
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("load_dmemREN", 32'(dmemREN), 32'd1);
    chk("load_imemREN", 32'(imemREN), 32'd0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("load_commit", 32'(pcEN), 32'd1);
    cycle(0, 0, 0, 0, 0);
    chk("load_done_dmemREN", 32'(dmemREN), 32'd0);
    chk("load_done_imemREN", 32'(imemREN), 32'd1);

    // store, then the decoder strobes change while the request is outstanding
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 1, 0, 0);
    chk("store_hold_wen", 32'(dmemWEN), 32'd1);
    chk("store_hold_ren", 32'(dmemREN), 32'd0);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // an illegal decode resolves to a write
    cycle(1, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0);
    chk("illegal_wen", 32'(dmemWEN), 32'd1);
    chk("illegal_ren", 32'(dmemREN), 32'd0);
    cycle(0, 1, 0, 0, 0);

    // halt wins over a store strobe, then stays sticky
    cycle(1, 0, 0, 1, 1);
    for (int k = 0; k < 10; k++)
      cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_no_wen", 32'(dmemWEN), 32'd0);

    // reset while a load is outstanding drops the request asynchronously
    do_reset();
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    @(negedge CLK);
    ihit = 0; dhit = 0; dRENi = 0; dWENi = 0; halt = 0;
    #2 nRST = 1'b0;
    #1;
    model_reset();
    chk("midrst_dmemREN", 32'(dmemREN), 32'd0);
    chk("midrst_imemREN", 32'(imemREN), 32'd1);
    chk_counters();
    @(negedge CLK);
    nRST = 1'b1;

    // saturation
    repeat (20) cycle(1, 0, 0, 0, 0);
`ifdef REQUEST_UNIT_PERF_EN
    #1 chk("ic_saturated", 32'(instr_count), 32'd15);
`endif

    // random traffic, with halt rare enough to leave long stretches active
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int k = 0; k < 80; k++) begin
        logic h;
        h = ($urandom_range(0, 39) == 0);
        cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), h);
        n_checks++;
        assert (!(dmemREN && dmemWEN) && !(imemREN && (dmemREN || dmemWEN))) else begin
          n_fail++;
          $error("FAIL invariant observed=%0b%0b%0b expected=exclusive", imemREN, dmemREN, dmemWEN);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Memory request sequencer directly downstream of the instruction decoder in the single-cycle datapath.
- Consumes the decoder's dRENi/dWENi/halt strobes, the instruction hit (ihit) and the data hit (dhit).
- Drives the instruction/data memory request lines to the cache/arbiter and the PC enable.
- Holds each data request stable until dhit, stalls the PC during memory access, and latches halt permanently.

Parameters:
- CNT_W, 32, width of the performance counters. Used only when REQUEST_UNIT_PERF_EN is defined.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction fetch complete this cycle.
- dhit  input  1  data access complete this cycle.
- dRENi  input  1  decoder: current instruction is a load.
- dWENi  input  1  decoder: current instruction is a store.
- halt  input  1  decoder: current instruction is HALT.
- imemREN  output  1  instruction read request.
- dmemREN  output  1  data read request (registered).
- dmemWEN  output  1  data write request (registered).
- pcEN  output  1  advance PC / commit the instruction this cycle (combinational).
- halted  output  1  processor halted, sticky.
- instr_count  output  CNT_W  retired instructions (REQUEST_UNIT_PERF_EN only).
- stall_count  output  CNT_W  stall cycles (REQUEST_UNIT_PERF_EN only).

Behaviour:
- Clock and reset: single clock CLK; nRST is asynchronous and active-low.
- Reset values: state=FETCH, dmemREN=0, dmemWEN=0, halted=0, counters=0.
- Reset outputs: imemREN=1, pcEN=0.
- States: FETCH, MEM, HALT. State, dmemREN, dmemWEN and halted are flops. imemREN and pcEN decode combinationally from the state and the inputs.

FETCH:
- imemREN=1.
- ihit=0: stay in FETCH, pcEN=0.
- ihit=1 & halt=1: go to HALT, pcEN=0, halted<=1. halt overrides any dRENi/dWENi in the same cycle.
- ihit=1 & dWENi=1: go to MEM, dmemWEN<=1, dmemREN<=0. Write has priority when dRENi and dWENi are both 1 (illegal decode); REN is suppressed.
- ihit=1 & dRENi=1 & dWENi=0: go to MEM, dmemREN<=1.
- ihit=1 with no access: pcEN=1 in the same cycle, stay in FETCH. Zero-latency commit for ALU/branch/jump instructions.
- dhit is ignored in FETCH.

MEM:
- imemREN=0; the data request owns the port.
- dmemREN/dmemWEN are held constant until dhit.
- dhit=0: stall, pcEN=0.
- dhit=1: pcEN=1 in the same cycle, dmemREN<=0, dmemWEN<=0, go to FETCH.
- ihit and the decoder strobes are ignored in MEM; the registered request is authoritative.
- Data access latency: the request asserts 1 cycle after the ihit edge; commit occurs on the dhit cycle.

HALT:
- imemREN=0, dmemREN=0, dmemWEN=0, pcEN=0, halted=1.
- Only nRST exits this state; all inputs are ignored.

Reset mid-operation:
- Asserting nRST in MEM drops dmemREN/dmemWEN asynchronously, with no wait for dhit.

Invariants:
- dmemREN and dmemWEN are never both 1.
- imemREN and any dmem request are never both 1.
- pcEN is at most one pulse per instruction.

Optional Feature:
- Macro: REQUEST_UNIT_PERF_EN.
- Defined: instr_count increments on every cycle with pcEN=1.
- Defined: stall_count increments on every cycle not in HALT where pcEN=0.
- Defined: both counters saturate at all-ones, reset to 0, and freeze in HALT.
- Undefined: instr_count/stall_count ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold nRST=0 -> imemREN=1, dmemREN=0, dmemWEN=0, pcEN=0, halted=0. Release and apply ihit=1 with no strobes for 3 cycles -> pcEN=1 on each of those cycles, instr_count=3.
- Load: ihit=1, dRENi=1 at cycle 0 -> cycle 1: dmemREN=1, imemREN=0. dhit held 0 for 2 cycles -> pcEN=0 and stall_count +2. dhit=1 at cycle 3 -> pcEN=1; cycle 4: dmemREN=0, imemREN=1.
- Store with the decode strobes changed while in MEM: ihit=1, dWENi=1, then dWENi=0, dRENi=1 in the next cycle -> dmemWEN stays 1 and dmemREN stays 0 until dhit.
- Illegal decode and halt priority:
  - dRENi=1 & dWENi=1 with ihit -> dmemWEN=1, dmemREN=0.
  - halt=1 & dWENi=1 with ihit -> HALT entered, no dmem request, halted=1.
  - halted stays 1 for 10 cycles of random ihit/dhit.
- Reset during MEM: dmemREN=1 and nRST pulsed low mid-cycle -> dmemREN=0 immediately (asynchronously), state=FETCH, counters=0.
- Saturation (CNT_W=4, macro defined): 20 single-cycle instructions -> instr_count=15 and holds at 15.
